// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C-to-MM bridge.
//   MM_ADDR_WIDTH_DEF / MM_DATA_WIDTH_DEF : default MM bus widths.
//   I2C_DEV_ADDR_DEF                      : default 7-bit device address.
//   i2c_state_e                           : protocol FSM states.
package i2c_slave_pkg;

  localparam int unsigned MM_ADDR_WIDTH_DEF = 8;
  localparam int unsigned MM_DATA_WIDTH_DEF = 16;
  localparam logic [6:0]  I2C_DEV_ADDR_DEF  = 7'h3A;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    DEV_ACK  = 4'd2,
    REG_ADDR = 4'd3,
    REG_ACK  = 4'd4,
    WR_DATA  = 4'd5,
    WR_ACK   = 4'd6,
    RD_DATA  = 4'd7,
    RD_ACK   = 4'd8
  } i2c_state_e;

endpackage

// File: rtl/i2c_filter.sv
// Input conditioning for one I2C line.
//   clk_sys_i : system clock
//   rst_n_i   : asynchronous active-low reset (pipeline presets to idle-high)
//   line_i    : raw asynchronous bus line
//   level_o   : filtered level
//   rise_o    : one-cycle pulse, coincident with level_o going 1
//   fall_o    : one-cycle pulse, coincident with level_o going 0
module i2c_filter (
  input  logic clk_sys_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [2:0] samp_q;
  logic       maj;

  // 2-of-3 vote rejects single-cycle glitches after synchronization.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[1] & samp_q[2]) |
               (samp_q[0] & samp_q[2]);

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '1;
      samp_q  <= '1;
      level_o <= 1'b1;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      samp_q  <= {samp_q[1:0], sync_q[1]};
      level_o <= maj;
      rise_o  <= maj & ~level_o;
      fall_o  <= ~maj & level_o;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C slave to memory-mapped master bridge.
//   clk_sys_i    : system clock
//   rst_n_i      : asynchronous active-low reset
//   i2c_scl_i    : bus clock (asynchronous)
//   i2c_sda_i    : bus data (asynchronous)
//   i2c_sda_oe_o : 1 = pull SDA low
//   mm_m_addr_o  : MM address (register byte in [7:0], post-increments)
//   mm_m_wdata_o : MM write data, {MSB byte, LSB byte}
//   mm_m_rdata_i : MM read data (combinational)
//   mm_m_we_o    : one-cycle write strobe
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter int unsigned MM_ADDR_WIDTH = MM_ADDR_WIDTH_DEF,
  parameter int unsigned MM_DATA_WIDTH = MM_DATA_WIDTH_DEF,
  parameter logic [6:0]  I2C_DEV_ADDR  = I2C_DEV_ADDR_DEF
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     i2c_scl_i,
  input  logic                     i2c_sda_i,
  output logic                     i2c_sda_oe_o,
  output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
  output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
  input  logic [MM_DATA_WIDTH-1:0] mm_m_rdata_i,
  output logic                     mm_m_we_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_filter u_scl_filt (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .line_i    (i2c_scl_i),
    .level_o   (scl),
    .rise_o    (scl_rise),
    .fall_o    (scl_fall)
  );

  i2c_filter u_sda_filt (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .line_i    (i2c_sda_i),
    .level_o   (sda),
    .rise_o    (sda_rise),
    .fall_o    (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  msb_q, msb_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        lsb_ph_q, lsb_ph_d;
  logic        ack_q, ack_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        inc_q, inc_d;

  logic [15:0] rdata;
  logic        rx_shift, byte_end;

  assign rdata    = 16'(mm_m_rdata_i);
  assign rx_shift = scl_rise && (bit_cnt_q != 4'd8);
  assign byte_end = scl_fall && (bit_cnt_q == 4'd8);

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      msb_q     <= '0;
      tx_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      lsb_ph_q  <= 1'b0;
      ack_q     <= 1'b0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      msb_q     <= msb_d;
      tx_q      <= tx_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      lsb_ph_q  <= lsb_ph_d;
      ack_q     <= ack_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      inc_q     <= inc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    msb_d     = msb_q;
    tx_d      = tx_q;
    wdata_d   = wdata_q;
    addr_d    = inc_q ? addr_q + 8'd1 : addr_q;
    rw_d      = rw_q;
    lsb_ph_d  = lsb_ph_q;
    ack_d     = ack_q;
    oe_d      = oe_q;
    we_d      = 1'b0;
    inc_d     = 1'b0;

    if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DEV_ADDR: begin
          if (rx_shift) begin
            sr_d      = {sr_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_end) begin
            bit_cnt_d = '0;
            if (sr_q[7:1] == I2C_DEV_ADDR) begin
              rw_d    = sr_q[0];
              oe_d    = 1'b1;
              state_d = DEV_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              // Word captured once here so both bytes come from the same read.
              tx_d     = rdata;
              oe_d     = ~rdata[15];
              lsb_ph_d = 1'b0;
              state_d  = RD_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = REG_ADDR;
            end
          end
        end
        REG_ADDR: begin
          if (rx_shift) begin
            sr_d      = {sr_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_end) begin
            bit_cnt_d = '0;
            addr_d    = sr_q;
            lsb_ph_d  = 1'b0;
            oe_d      = 1'b1;
            state_d   = REG_ACK;
          end
        end
        REG_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_shift) begin
            sr_d      = {sr_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_end) begin
            bit_cnt_d = '0;
            if (!lsb_ph_q) msb_d = sr_q;
            oe_d    = 1'b1;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            oe_d     = 1'b0;
            state_d  = WR_DATA;
            lsb_ph_d = ~lsb_ph_q;
            if (lsb_ph_q) begin
              wdata_d = {msb_q, sr_q};
              we_d    = 1'b1;
              inc_d   = 1'b1;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            // Shift also on the last fall so tx_q[15] holds the LSB byte's MSB.
            tx_d = tx_q << 1;
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              oe_d      = 1'b0;
              state_d   = RD_ACK;
              if (lsb_ph_q) inc_d = 1'b1;
            end else begin
              oe_d = ~tx_q[14];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda;
          end else if (scl_fall) begin
            if (ack_q) begin
              state_d = RD_DATA;
              if (lsb_ph_q) begin
                lsb_ph_d = 1'b0;
                tx_d     = rdata;
                oe_d     = ~rdata[15];
              end else begin
                lsb_ph_d = 1'b1;
                oe_d     = ~tx_q[15];
              end
            end else begin
              state_d = IDLE;
              oe_d    = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign i2c_sda_oe_o = oe_q;
  assign mm_m_we_o    = we_q;
  assign mm_m_addr_o  = MM_ADDR_WIDTH'(addr_q);
  assign mm_m_wdata_o = MM_DATA_WIDTH'(wdata_q);

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter MM_ADDR_WIDTH, default 8, sets the MM address width; register-address byte maps to mm_m_addr_o[7:0].
REQ-002 Parameter MM_DATA_WIDTH, default 16, sets the MM data width; one word is transferred as two bytes, MSB first.
REQ-003 Parameter I2C_DEV_ADDR, default 7'h3A, is the 7-bit device address this block answers to.
REQ-004 clk_sys_i  input  1  system clock; the single clock of the block.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 i2c_scl_i  input  1  I2C clock from the bus master, asynchronous to clk_sys_i.
REQ-007 i2c_sda_i  input  1  I2C data as seen on the bus, asynchronous.
REQ-008 i2c_sda_oe_o  output  1  1 = pull SDA low; the top level converts this to an open-drain pin.
REQ-009 mm_m_addr_o  output  MM_ADDR_WIDTH  MM master address.
REQ-010 mm_m_wdata_o  output  MM_DATA_WIDTH  MM master write data.
REQ-011 mm_m_rdata_i  input  MM_DATA_WIDTH  MM master read data, combinational from the interconnect.
REQ-012 mm_m_we_o  output  1  MM write strobe, one clk_sys_i cycle wide.

Function
REQ-013 SCL and SDA SHALL each pass a 2-FF synchronizer, then a 3-sample majority filter; all protocol logic uses the filtered values only.
REQ-014 START SHALL be detected as filtered SDA 1->0 while filtered SCL is 1; STOP as SDA 0->1 while SCL is 1.
REQ-015 SDA SHALL be sampled on the filtered SCL rising edge; i2c_sda_oe_o SHALL change only on the cycle after a filtered SCL falling edge.
REQ-016 FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-017 START or repeated START in any state SHALL go to DEV_ADDR with the bit counter cleared; STOP in any state SHALL go to IDLE and release SDA.
REQ-018 DEV_ADDR: after 8 bits, address match -> DEV_ACK (drive ACK low for the 9th bit); mismatch -> IDLE with SDA never driven.
REQ-019 After DEV_ACK: R/W=0 -> REG_ADDR; R/W=1 -> RD_DATA.
REQ-020 REG_ADDR: 8 bits are loaded into mm_m_addr_o, then REG_ACK, then WR_DATA; a byte-phase flag SHALL be cleared to MSB.
REQ-021 WR_DATA/WR_ACK: the slave ACKs every byte; after the LSB ACK, mm_m_wdata_o gets {MSB,LSB} and mm_m_we_o pulses exactly one cycle.
REQ-022 The address SHALL post-increment by 1 one cycle after each write pulse and after each completed read word; wrap 8'hFF -> 8'h00.
REQ-023 RD_DATA: mm_m_rdata_i SHALL be captured into a 16-bit shift buffer at entry to the MSB byte; the MSB and then the LSB are shifted out from that buffer, so the word is atomic.
REQ-024 RD_ACK: master ACK -> next byte (and, after the LSB, a new word at the incremented address); master NACK -> IDLE, waiting for STOP/START.
REQ-025 Driving a data bit of 1 SHALL release SDA (oe=0); a bit of 0 SHALL set oe=1.
REQ-026 If a write ends after the MSB only (STOP/Sr), no write strobe SHALL occur and the partial byte is discarded.
REQ-027 Clock stretching is not supported; SCL is never driven.

Reset
REQ-028 On rst_n_i low (asynchronous) the FSM SHALL go to IDLE, i2c_sda_oe_o=0, mm_m_we_o=0, mm_m_addr_o=0, mm_m_wdata_o=0, and the filters SHALL be preset to 1 (idle bus).
REQ-029 Reset asserted mid-transfer SHALL release SDA within the same cycle, with no write strobe; after release the block waits for a fresh START.

Structure
REQ-030 The FSM state encodings and the default device address SHALL live in the shared iohub defines package, alongside the MM width constants.
REQ-031 One sub-module, i2c_filter (synchronizer + majority filter + rise/fall pulses), SHALL be instantiated once for SCL and once for SDA.
REQ-032 The MM port set SHALL be pin-compatible with the SPI slave master side, so the top level can select either bridge for the mm_con master port.

Verification
REQ-033 Write to 0x3A, reg 0x10, data 0x12,0x34 -> one mm_m_we_o pulse with addr 0x10 and wdata 0x1234; ACK low on all 4 ACK slots.
REQ-034 Write to 0x3A, reg 0x10, then Sr with read 0x3A, mm_m_rdata_i=0xBEEF -> bytes 0xBE, 0xEF on SDA; NACK -> IDLE.
REQ-035 Device address 0x3B -> SDA never driven, no strobe, FSM stays IDLE until the next START.
REQ-036 Burst write at reg 0xFF, two words 0x0001, 0x0002 -> strobes at addr 0xFF then 0x00.
REQ-037 A 1-cycle SDA glitch while SCL is high -> no START/STOP detected and the transfer completes normally.
REQ-038 rst_n_i pulsed low during the WR_DATA LSB -> oe=0 immediately, no strobe; a following full write succeeds.
